// File: rtl/seq_divider.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Valid/ready handshakes on operand and result sides; all outputs are registered.
module seq_divider #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int DW = 2 * W;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      pr_q, pr_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [DW-1:0]   qacc_q, qacc_d;
    logic [DW-1:0]   quotient_q, quotient_d;
    logic [W-1:0]    remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    // One restoring step: the extra pr bit only serves the compare.
    logic [W:0]      pr_shift;
    logic            pr_ge;
    logic [W:0]      pr_step;

    always_comb begin
        pr_shift = {pr_q[W-1:0], dvd_q[DW-1]};
        pr_ge    = (pr_shift >= {1'b0, dvs_q});
        pr_step  = pr_ge ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a variable unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        pr_d        = pr_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        qacc_d      = qacc_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d      = dividend;
                    dvs_d      = divisor;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(DW - 1);
                        pr_d    = '0;
                        qacc_d  = '0;
                    end
                end
            end
            CALC: begin
                pr_d   = pr_step;
                dvd_d  = {dvd_q[DW-2:0], 1'b0};
                qacc_d = {qacc_q[DW-2:0], pr_ge};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = {qacc_q[DW-2:0], pr_ge};
                    remainder_d = pr_step[W-1:0];
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // in_ready stays low here, so a result handshake never overlaps a new accept.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pr_q        <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            qacc_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pr_q        <= pr_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            qacc_q      <= qacc_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
